// File: rtl/track_ctrl_fsm.sv
// Multi-track record/loop-play controller. Each track runs its own small FSM.
// One write pointer is shared by all tracks because only one track can record at a time.
// Every track has its own read pointer and take length.
module track_ctrl_fsm #(
  parameter int unsigned NUM_TRACKS  = 2,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         sample_tick,
  input  logic [NUM_TRACKS-1:0]        rec_sw,
  input  logic [NUM_TRACKS-1:0]        play_sw,
  output logic [NUM_TRACKS-1:0]        rec_en,
  output logic [NUM_TRACKS-1:0]        play_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [NUM_TRACKS*ADDR_W-1:0] rd_addr,
  output logic [NUM_TRACKS*ADDR_W-1:0] track_len,
  output logic [NUM_TRACKS-1:0]        track_valid,
  output logic [NUM_TRACKS-1:0]        full,
  output logic [NUM_TRACKS-1:0]        loop_wrap
);

  typedef enum logic [1:0] {StIdle, StRec, StPlay, StFull} state_e;

  localparam logic [ADDR_W-1:0] MaxAddr  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LastFree = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] One      = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e                state_q [NUM_TRACKS];
  state_e                state_d [NUM_TRACKS];
  logic [ADDR_W-1:0]     rd_q    [NUM_TRACKS];
  logic [ADDR_W-1:0]     rd_d    [NUM_TRACKS];
  logic [ADDR_W-1:0]     len_q   [NUM_TRACKS];
  logic [ADDR_W-1:0]     len_d   [NUM_TRACKS];
  logic [ADDR_W-1:0]     wr_q, wr_d;
  logic [NUM_TRACKS-1:0] valid_q, valid_d, full_q, full_d, wrap_q, wrap_d;
  logic [NUM_TRACKS-1:0] rec_sync_q  [SYNC_STAGES];
  logic [NUM_TRACKS-1:0] play_sync_q [SYNC_STAGES];
  logic [NUM_TRACKS-1:0] rec_s, play_s;
  logic                  busy;
  logic                  granted;

  // Synchronise the asynchronous switch levels into the clock domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        rec_sync_q[s]  <= '0;
        play_sync_q[s] <= '0;
      end
    end else begin
      rec_sync_q[0]  <= rec_sw;
      play_sync_q[0] <= play_sw;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        rec_sync_q[s]  <= rec_sync_q[s-1];
        play_sync_q[s] <= play_sync_q[s-1];
      end
    end
  end

  assign rec_s  = rec_sync_q[SYNC_STAGES-1];
  assign play_s = play_sync_q[SYNC_STAGES-1];

  // A recording or full track owns the write pointer and blocks any new record.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(NUM_TRACKS); i++) begin
      if (state_q[i] == StRec || state_q[i] == StFull) busy = 1'b1;
    end
  end

  // Next-state logic for every track, plus the shared write pointer.
  always_comb begin
    granted = busy;
    wr_d    = wr_q;
    valid_d = valid_q;
    full_d  = full_q;
    wrap_d  = '0;
    for (int i = 0; i < int'(NUM_TRACKS); i++) begin
      state_d[i] = state_q[i];
      rd_d[i]    = rd_q[i];
      len_d[i]   = len_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (play_s[i]) begin
            if (valid_q[i]) begin
              state_d[i] = StPlay;
              rd_d[i]    = '0;
            end
          end else if (rec_s[i] && !granted) begin
            // The loop runs from the lowest index up, so the lowest requester wins.
            granted    = 1'b1;
            state_d[i] = StRec;
            wr_d       = '0;
            valid_d[i] = 1'b0;
            full_d[i]  = 1'b0;
          end
        end
        StRec: begin
          if (sample_tick) wr_d = wr_q + One;
          if (!rec_s[i]) begin
            // A tick that arrives in the exit cycle still belongs to the take.
            state_d[i] = StIdle;
            len_d[i]   = wr_q + (sample_tick ? One : '0);
            valid_d[i] = (wr_q != '0) || sample_tick;
          end else if (sample_tick && wr_q == LastFree) begin
            state_d[i] = StFull;
            len_d[i]   = MaxAddr;
            valid_d[i] = 1'b1;
            full_d[i]  = 1'b1;
          end
        end
        StPlay: begin
          if (!play_s[i]) begin
            state_d[i] = StIdle;
            rd_d[i]    = '0;
          end else if (sample_tick) begin
            if (rd_q[i] == len_q[i] - One) begin
              rd_d[i]   = '0;
              wrap_d[i] = 1'b1;
            end else begin
              rd_d[i] = rd_q[i] + One;
            end
          end
        end
        StFull: begin
          if (!rec_s[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // State and pointer registers. An asynchronous reset throws away any take in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_TRACKS); i++) begin
        state_q[i] <= StIdle;
        rd_q[i]    <= '0;
        len_q[i]   <= '0;
      end
      wr_q    <= '0;
      valid_q <= '0;
      full_q  <= '0;
      wrap_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_TRACKS); i++) begin
        state_q[i] <= state_d[i];
        rd_q[i]    <= rd_d[i];
        len_q[i]   <= len_d[i];
      end
      wr_q    <= wr_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      wrap_q  <= wrap_d;
    end
  end

  // Moore outputs, decoded from the registered state.
  always_comb begin
    rec_en    = '0;
    play_en   = '0;
    rd_addr   = '0;
    track_len = '0;
    for (int i = 0; i < int'(NUM_TRACKS); i++) begin
      rec_en[i]                    = (state_q[i] == StRec);
      play_en[i]                   = (state_q[i] == StPlay);
      rd_addr[i*ADDR_W +: ADDR_W]   = rd_q[i];
      track_len[i*ADDR_W +: ADDR_W] = len_q[i];
    end
  end

  assign wr_addr     = wr_q;
  assign track_valid = valid_q;
  assign full        = full_q;
  assign loop_wrap   = wrap_q;

endmodule

// File: tb/tb_track_ctrl_fsm.sv
// Directed bench for track_ctrl_fsm with 2 tracks, 4-bit addresses and 2 sync stages.
module tb_track_ctrl_fsm;

  localparam int unsigned NT = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            sample_tick;
  logic [NT-1:0]   rec_sw, play_sw;
  logic [NT-1:0]   rec_en, play_en, track_valid, full, loop_wrap;
  logic [AW-1:0]   wr_addr;
  logic [NT*AW-1:0] rd_addr, track_len;

  int n_checks = 0;
  int n_errors = 0;
  int wraps;

  track_ctrl_fsm #(
    .NUM_TRACKS (NT),
    .ADDR_W     (AW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sample_tick(sample_tick),
    .rec_sw     (rec_sw),
    .play_sw    (play_sw),
    .rec_en     (rec_en),
    .play_en    (play_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .track_len  (track_len),
    .track_valid(track_valid),
    .full       (full),
    .loop_wrap  (loop_wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle sample strobe. On return we sit just after the edge that consumed it.
  task automatic pulse_tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {rec_en, play_en, track_valid, full, loop_wrap, wr_addr}, 32'h0);
    check_eq({tag, "_rd"}, rd_addr, 32'h0);
    check_eq({tag, "_len"}, track_len, 32'h0);
  endtask

  initial begin
    resetn      = 1'b0;
    sample_tick = 1'b0;
    rec_sw      = '0;
    play_sw     = '0;
    step(2);
    check_all_zero("reset");
    resetn = 1'b1;
    step(1);

    // 1: record 5 samples on track 0
    rec_sw = 2'b01;
    step(2);
    check_eq("rec_en_edge2", rec_en, 2'b00);
    step(1);
    check_eq("rec_en_edge3", rec_en, 2'b01);
    check_eq("wr_start", wr_addr, 0);
    for (int k = 1; k <= 5; k++) begin
      pulse_tick();
      check_eq("wr_inc", wr_addr, k);
      step(1);
    end
    rec_sw = 2'b00;
    step(2);
    check_eq("rec_hold_sync", rec_en, 2'b01);
    step(1);
    check_eq("rec_exit", rec_en, 2'b00);
    check_eq("len0", track_len[AW-1:0], 5);
    check_eq("valid0", track_valid, 2'b01);

    // 2: loop-play track 0 over 12 ticks
    play_sw = 2'b01;
    step(3);
    check_eq("play_en0", play_en, 2'b01);
    check_eq("rd0_start", rd_addr[AW-1:0], 0);
    wraps = 0;
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      check_eq("rd0", rd_addr[AW-1:0], k % 5);
      check_eq("wrap0", loop_wrap, (k % 5 == 0) ? 2'b01 : 2'b00);
      if (loop_wrap[0]) wraps++;
      step(1);
      check_eq("wrap0_clear", loop_wrap, 2'b00);
    end
    check_eq("wrap_count", wraps, 2);

    // 5b: a record request during playback is ignored
    rec_sw = 2'b01;
    step(4);
    check_eq("rec_in_play", rec_en, 2'b00);
    check_eq("still_play", play_en, 2'b01);
    rec_sw  = 2'b00;
    play_sw = 2'b00;
    step(3);
    check_eq("play_stop", play_en, 2'b00);
    check_eq("rd0_reset", rd_addr[AW-1:0], 0);

    // 5a: play on an empty track does nothing
    play_sw = 2'b10;
    step(4);
    check_eq("play_empty", play_en, 2'b00);
    play_sw = 2'b00;
    step(3);

    // 3: fill track 1 to capacity
    rec_sw = 2'b10;
    step(3);
    check_eq("rec1_start", rec_en, 2'b10);
    for (int k = 1; k <= 20; k++) begin
      pulse_tick();
      check_eq("wr_cap", wr_addr, (k < 15) ? k : 15);
      check_eq("rec1_en", rec_en[1], (k < 15) ? 1 : 0);
      check_eq("full1", full[1], (k >= 15) ? 1 : 0);
      step(1);
    end
    check_eq("len1_full", track_len[2*AW-1:AW], 15);
    check_eq("valid_full", track_valid, 2'b11);
    rec_sw = 2'b00;
    step(3);
    check_eq("full1_sticky", full, 2'b10);

    // 4: simultaneous requests, the lowest index wins, then track 1 takes over
    rec_sw = 2'b11;
    step(3);
    check_eq("grant_low", rec_en, 2'b01);
    check_eq("wr_regrant", wr_addr, 0);
    pulse_tick();
    step(1);
    pulse_tick();
    step(1);
    rec_sw = 2'b10;
    step(3);
    check_eq("handoff_gap", rec_en, 2'b00);
    check_eq("len0_new", track_len[AW-1:0], 2);
    step(1);
    check_eq("rec1_again", rec_en, 2'b10);
    check_eq("wr_restart", wr_addr, 0);
    check_eq("full1_cleared", full, 2'b00);
    check_eq("valid1_cleared", track_valid, 2'b01);

    // 6: asynchronous reset in the middle of a record
    for (int k = 1; k <= 7; k++) begin
      pulse_tick();
      step(1);
    end
    check_eq("wr_pre_reset", wr_addr, 7);
    #3;
    resetn = 1'b0;
    #1;
    check_all_zero("async_rst");
    rec_sw = 2'b00;
    step(2);
    resetn = 1'b1;
    step(3);
    check_all_zero("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/track_ctrl_fsm.md
Name: track_ctrl_fsm

Overview:
Parametrised successor to the two-track record/play controller. Drives NUM_TRACKS independent track state machines. Each track can record a take into its RAM and then loop-play it back at the sample rate. Provides the write pointer, per-track read pointers and take lengths, so the RAM and mixer datapath need no address logic of their own. Sits between the board switches (SW) and the per-track sample RAMs.

Parameters:
NUM_TRACKS, 2, number of tracks (1..8)
ADDR_W, 12, RAM address width; a track holds at most 2^ADDR_W-1 samples
SYNC_STAGES, 2, flop stages on each switch input (>=2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe, one per audio sample
rec_sw  in  NUM_TRACKS  record request per track, level, asynchronous
play_sw  in  NUM_TRACKS  play request per track, level, asynchronous
rec_en  out  NUM_TRACKS  track i RAM write enable (qualify with sample_tick)
play_en  out  NUM_TRACKS  track i playback active
wr_addr  out  ADDR_W  shared write pointer (only one track records at a time)
rd_addr  out  NUM_TRACKS*ADDR_W  per-track read pointer, track i at [i*ADDR_W +: ADDR_W]
track_len  out  NUM_TRACKS*ADDR_W  captured take length per track, same packing
track_valid  out  NUM_TRACKS  track holds a non-empty take
full  out  NUM_TRACKS  track stopped recording on capacity
loop_wrap  out  NUM_TRACKS  one-cycle pulse when rd_addr of track i wraps to 0

Behaviour:
- Reset (async, resetn=0): all tracks IDLE. All outputs 0, all pointers 0, track_len 0, track_valid 0, synchroniser flops 0.
- rec_sw and play_sw pass through SYNC_STAGES flops (rec_s, play_s). All decisions use the synchronised values.
- A switch change reaches the state register on the (SYNC_STAGES+1)th rising edge. Outputs are Moore, decoded from registered state and pointers.
- Per-track states: IDLE, REC, PLAY, FULL.
- IDLE->PLAY: play_s[i]=1 and track_valid[i]=1. rd_addr[i] is set to 0. If play_s[i]=1 and track_valid[i]=0, the track stays IDLE.
- IDLE->REC: all of the following hold:
  - rec_s[i]=1 and play_s[i]=0;
  - no track is in REC or FULL;
  - i is the lowest index satisfying these conditions this cycle.
  - On entry: wr_addr=0, track_valid[i]=0, full[i]=0.
- REC: rec_en[i]=1. Each sample_tick increments wr_addr by 1.
- REC exit on rec_s[i]=0:
  - track_len[i] = wr_addr + sample_tick, so a tick in the exit cycle is counted.
  - track_valid[i] = (track_len[i] != 0).
  - Next state is IDLE.
- REC exit on capacity: when wr_addr reaches 2^ADDR_W-1 (after the increment), the track goes to FULL.
  - track_len[i] = 2^ADDR_W-1, track_valid[i]=1, full[i]=1, rec_en[i]=0.
  - wr_addr does not wrap.
- FULL: rec_en=0, wr_addr holds. On rec_s[i]=0 the track returns to IDLE; full[i] stays set until the next REC entry. The track cannot retrigger until its switch is released.
- PLAY: play_en[i]=1. On sample_tick, rd_addr[i] increments. If rd_addr[i]==track_len[i]-1, it instead becomes 0 and loop_wrap[i] pulses for 1 cycle (registered, in the cycle after the tick).
- Single-sample take: with track_len=1, rd_addr stays 0 and loop_wrap pulses on every tick.
- PLAY->IDLE on play_s[i]=0. rd_addr[i] returns to 0.
- Any rec_s[i] while in PLAY is ignored. The track re-evaluates in IDLE on the next cycle.
- sample_tick is ignored in IDLE and FULL.
- Multiple tracks may be in PLAY at once, each with its own independent pointer.
- Reset asserted mid-record discards the take: track_len=0, track_valid=0.

Test Plan:
1. ADDR_W=4, SYNC_STAGES=2. Set rec_sw=01, give 5 ticks, drop rec_sw -> rec_en[0] high from edge 3, wr_addr 0..5, track_len[0]=5, track_valid[0]=1.
2. Play track 0 with len=5 over 12 ticks -> rd_addr 0,1,2,3,4,0,1,2,3,4,0,1; loop_wrap[0] pulses twice.
3. ADDR_W=4. Hold rec_sw[1] for 20 ticks -> FULL after wr_addr=15, track_len[1]=15, full[1]=1, rec_en[1]=0. Releasing the switch -> IDLE.
4. rec_sw=11 asserted in the same cycle -> track 0 records, track 1 stays IDLE. Drop rec_sw[0] -> track 1 enters REC with wr_addr=0.
5. play_sw[1]=1 with track_valid[1]=0 -> play_en[1] stays 0. Raise rec_sw[0] during PLAY of track 0 -> ignored.
6. Pulse resetn low mid-REC with wr_addr=7 -> all outputs 0 immediately, asynchronously; track_valid=0 after release.
